fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Per-FIFO write-side round-robin arbiter: grants one frame dispatcher per packet
// and muxes its beats into the FIFO write port. Optional idle-beat release: ARB_TIMEOUT_EN.
module fifo_wr_arbiter #(
  parameter int unsigned PORT_NUM = 6,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORT_NUM-1:0]        bus_sel,
  input  logic [PORT_NUM*DATA_W-1:0] fd_data,
  input  logic [PORT_NUM-1:0]        fd_valid,
  input  logic [PORT_NUM-1:0]        fd_eop,
  output logic [PORT_NUM-1:0]        fd_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_wr_data,
  output logic [PORT_NUM-1:0]        grant,
  output logic                       busy,
  output logic                       timeout
);

  localparam int unsigned PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("fifo_wr_arbiter: TIMEOUT must be within 1..255");
  end

  typedef enum logic {IDLE, XFER} state_e;

  state_e              state_q, state_d;
  logic [PORT_NUM-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]    last_ptr_q, last_ptr_d;
  logic [PTR_W-1:0]    sel_idx, scan_idx;
  logic                found;
  logic                valid_g, eop_g, accept;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // The grant is one-hot (zero when idle), so masking selects the granted port.
  assign valid_g = |(fd_valid & grant_q);
  assign eop_g   = |(fd_eop & grant_q);
  assign accept  = valid_g & ~fifo_full;

  assign fifo_wr_en = accept;
  assign fd_ready   = grant_q & {PORT_NUM{~fifo_full}};
  assign grant      = grant_q;
  assign busy       = (state_q == XFER);

  always_comb begin
    fifo_wr_data = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (grant_q[p]) fifo_wr_data = fd_data[p*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_ptr_q <= PTR_W'(PORT_NUM - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Next state; last_ptr doubles as the granted index while in XFER.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    found      = 1'b0;
    sel_idx    = '0;
    scan_idx   = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = '0;
    timeout_d  = 1'b0;
`endif

    // Round-robin scan upward from the port after the last winner.
    for (int unsigned i = 1; i <= PORT_NUM; i++) begin
      scan_idx = PTR_W'((32'(last_ptr_q) + i) % PORT_NUM);
      if (!found && bus_sel[scan_idx]) begin
        found   = 1'b1;
        sel_idx = scan_idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          last_ptr_d       = sel_idx;
          state_d          = XFER;
        end
      end
      XFER: begin
        if (accept && eop_g) begin
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (!valid_g) begin
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            grant_d   = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-port packet queues drive the dispatchers,
// expected {grant, data} beats are queued at stimulus time and popped on each FIFO write.
module tb_fifo_wr_arbiter;

  localparam int unsigned PN = 6;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PN-1:0]     bus_sel = '0;
  logic [PN*DW-1:0]  fd_data = '0;
  logic [PN-1:0]     fd_valid = '0;
  logic [PN-1:0]     fd_eop = '0;
  logic [PN-1:0]     fd_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic [PN-1:0]     grant;
  logic              busy;
  logic              timeout;

  fifo_wr_arbiter #(.PORT_NUM(PN), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .fd_data(fd_data),
    .fd_valid(fd_valid), .fd_eop(fd_eop), .fd_ready(fd_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PN-1:0] g;
    logic [DW-1:0] d;
  } exp_t;

  logic [DW:0]   pq [PN][$];
  exp_t          exp_q [$];
  int            wr_cyc [$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic          force_en = 1'b0;
  logic [PN-1:0] force_sel = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_ports();
    logic [PN-1:0] pend;
    pend = '0;
    for (int p = 0; p < PN; p++) begin
      if (pq[p].size() > 0) begin
        pend[p]             = 1'b1;
        fd_valid[p]         = 1'b1;
        fd_eop[p]           = pq[p][0][DW];
        fd_data[p*DW +: DW] = pq[p][0][DW-1:0];
      end else begin
        fd_valid[p]         = 1'b0;
        fd_eop[p]           = 1'b0;
        fd_data[p*DW +: DW] = '0;
      end
    end
    bus_sel = force_en ? force_sel : pend;
  endtask

  task automatic add_pkt(input int p, input int n, input int id);
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = {4'(p), 4'(id), 8'(k)};
      pq[p].push_back({(k == n - 1), d});
      exp_q.push_back({PN'(1) << p, d});
    end
  endtask

  // Dispatcher model: handshake sampled mid-cycle, accepted beats retired after the edge.
  initial begin
    logic [PN-1:0] acc;
    forever begin
      @(negedge clk);
      acc = fd_valid & fd_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < PN; p++)
        if (acc[p] && pq[p].size() > 0) void'(pq[p].pop_front());
      drive_ports();
    end
  end

  // Write monitor: every FIFO write must match the next expected beat and grant.
  always @(negedge clk) begin
    if (rst_n && fifo_wr_en) begin
      check_eq("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("wr_data", 32'(fifo_wr_data), 32'(e.d));
        check_eq("wr_grant", 32'(grant), 32'(e.g));
        wr_cyc.push_back(cyc);
      end
    end
  end

  task automatic check_idle_outs(input string tag);
    check_eq({tag, "_grant"}, 32'(grant), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_ready"}, 32'(fd_ready), 32'd0);
    check_eq({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    check_eq({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
    check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic clear_stim();
    for (int p = 0; p < PN; p++) pq[p].delete();
    exp_q.delete();
    wr_cyc.delete();
    force_en  = 1'b0;
    force_sel = '0;
    fifo_full = 1'b0;
    drive_ports();
  endtask

  task automatic reset_dut(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_stim();
    repeat (2) @(negedge clk);
    check_idle_outs(tag);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int left;
    bit pend;
    left = budget;
    do begin
      @(posedge clk);
      pend = (exp_q.size() != 0);
      for (int p = 0; p < PN; p++) if (pq[p].size() != 0) pend = 1'b1;
      left--;
    end while (pend && left > 0);
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: single request, 3-beat packet on port 2
    reset_dut("rst1");
    add_pkt(2, 3, 1);
    drive_ports();
    @(negedge clk);
    check_eq("t1_grant_pre", 32'(grant), 32'd0);
    @(negedge clk);
    check_eq("t1_grant", 32'(grant), 32'b000100);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_drain("t1", 50);
    @(negedge clk);
    check_eq("t1_grant_after", 32'(grant), 32'd0);
    check_eq("t1_busy_after", 32'(busy), 32'd0);

    // T2: all ports, single-beat packets, round-robin with one bubble between
    reset_dut("rst2");
    for (int p = 0; p < PN; p++) add_pkt(p, 1, 2);
    add_pkt(0, 1, 3);
    drive_ports();
    wait_drain("t2", 100);
    check_eq("t2_writes", 32'(wr_cyc.size()), 32'd7);
    for (int i = 1; i < wr_cyc.size(); i++)
      check_eq("t2_gap", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);

    // T3: port 1, fifo_full for 4 cycles mid-packet
    reset_dut("rst3");
    add_pkt(1, 6, 4);
    drive_ports();
    repeat (2) begin @(posedge clk); #2; end
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t3_full_wr_en", 32'(fifo_wr_en), 32'd0);
      check_eq("t3_full_ready", 32'(fd_ready), 32'd0);
      check_eq("t3_full_grant", 32'(grant), 32'b000010);
      @(posedge clk);
      #2;
    end
    fifo_full = 1'b0;
    @(negedge clk);
    check_eq("t3_ready_resume", 32'(fd_ready), 32'b000010);
    wait_drain("t3", 50);

    // T4: port 3 granted, bus_sel moves to port 0 mid-packet
    reset_dut("rst4");
    add_pkt(3, 4, 5);
    drive_ports();
    repeat (2) begin @(posedge clk); #2; end
    force_en  = 1'b1;
    force_sel = 6'b000001;
    add_pkt(0, 2, 6);
    drive_ports();
    @(negedge clk);
    check_eq("t4_grant_held", 32'(grant), 32'b001000);
    wait_drain("t4", 50);

    // T5: port 4 granted with no data
    reset_dut("rst5");
    force_en  = 1'b1;
    force_sel = 6'b010000;
    drive_ports();
    @(posedge clk);
    #2;
    force_sel = '0;
    drive_ports();
    @(negedge clk);
    check_eq("t5_grant", 32'(grant), 32'b010000);
    repeat (9) @(negedge clk);
    check_eq("t5_grant_c10", 32'(grant), 32'b010000);
    check_eq("t5_timeout_c10", 32'(timeout), 32'd0);
`ifdef ARB_TIMEOUT_EN
    @(negedge clk);
    check_eq("t5_grant_released", 32'(grant), 32'd0);
    check_eq("t5_timeout_pulse", 32'(timeout), 32'd1);
    check_eq("t5_busy_released", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("t5_timeout_end", 32'(timeout), 32'd0);
`else
    repeat (20) @(negedge clk);
    check_eq("t5_grant_kept", 32'(grant), 32'b010000);
    check_eq("t5_busy_kept", 32'(busy), 32'd1);
    check_eq("t5_timeout_tied", 32'(timeout), 32'd0);
`endif

    // T6: reset mid-packet on port 5, then port 0 wins first again
    reset_dut("rst6");
    add_pkt(5, 5, 7);
    drive_ports();
    repeat (3) begin @(posedge clk); #2; end
    check_eq("t6_wr_before_rst", 32'(fifo_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outs("t6_async");
    clear_stim();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    add_pkt(0, 1, 8);
    add_pkt(5, 1, 9);
    drive_ports();
    repeat (2) @(negedge clk);
    check_eq("t6_grant_port0", 32'(grant), 32'b000001);
    wait_drain("t6", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
